// File: rtl/mac_stream_pkg.sv
// Shared types for the streaming multiply-accumulate engine.
package mac_stream_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    localparam int RES_AW = 9;

    typedef struct packed {
        logic signed [RES_AW-1:0] acc_out;
        logic signed [RES_AW-1:0] acc_prev;
        logic                     ovf;
    } mac_result_t;

endpackage

// File: rtl/mac_stream_if.sv
// Operand-in / result-out handshake bundle of mac_stream.
interface mac_stream_if #(
    parameter int DW = 9,
    parameter int AW = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] acc_out;
    logic signed [AW-1:0] acc_prev;
    logic                 ovf;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, acc_out, acc_prev, ovf
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, acc_out, acc_prev, ovf
    );
endinterface

// File: rtl/mac_stream_step.sv
// Combinational product + sum with width reduction (wrap or clamp).
module mac_step
    import mac_stream_pkg::*;
#(
    parameter int DW  = 9,
    parameter int AW  = 9,
    parameter int SAT = SAT_WRAP
) (
    input  logic signed [AW-1:0] acc,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    output logic signed [AW-1:0] acc_next,
    output logic signed [AW-1:0] acc_prev,
    output logic                 step_ovf
);
    // Wide enough to hold both the exact product and the exact AW+1 sum.
    localparam int EW = (2*DW > AW+1) ? 2*DW : AW+1;
    localparam logic signed [EW-1:0] AMAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [EW-1:0] AMIN = ~AMAX;

    // Returns {flag, value}: flag set when the reduced value differs from v.
    function automatic logic [AW:0] reduce(input logic signed [EW-1:0] v);
        logic [AW:0] r;
        r = {1'b0, v[AW-1:0]};
        if (SAT == SAT_CLAMP) begin
            if (v > AMAX)      r = {1'b1, AMAX[AW-1:0]};
            else if (v < AMIN) r = {1'b1, AMIN[AW-1:0]};
        end else if (v != {{(EW-AW){v[AW-1]}}, v[AW-1:0]}) begin
            r[AW] = 1'b1;
        end
        return r;
    endfunction

    logic signed [EW-1:0] xe, ye, pe, se;
    logic        [AW:0]   pr, sr;

    always_comb begin
        xe       = {{(EW-DW){x[DW-1]}}, x};
        ye       = {{(EW-DW){y[DW-1]}}, y};
        pe       = xe * ye;
        pr       = reduce(pe);
        se       = {{(EW-AW){acc[AW-1]}}, acc} + {{(EW-AW){pr[AW-1]}}, pr[AW-1:0]};
        sr       = reduce(se);
        acc_next = sr[AW-1:0];
        acc_prev = acc;
        step_ovf = pr[AW] | sr[AW];
    end
endmodule

// File: rtl/mac_stream.sv
// Handshaked dot-product engine: LEN accepted pairs per result, then HOLD.
module mac_stream
    import mac_stream_pkg::*;
#(
    parameter int DW  = 9,
    parameter int AW  = 9,
    parameter int LEN = 4,
    parameter int SAT = SAT_WRAP
) (
    input  logic         system1000,
    input  logic         system1000_rst,
    mac_stream_if.slave  bus
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    mac_state_t           state_q, state_d;
    logic        [CW-1:0] cnt;
    logic signed [AW-1:0] acc, acc_next, step_prev;
    logic signed [AW-1:0] acc_out_q, acc_prev_q;
    logic                 ovf_trk, ovf_q, step_ovf;
    logic                 accept, last;

    mac_step #(.DW(DW), .AW(AW), .SAT(SAT)) u_step (
        .acc      (acc),
        .x        (bus.x),
        .y        (bus.y),
        .acc_next (acc_next),
        .acc_prev (step_prev),
        .step_ovf (step_ovf)
    );

    always_comb begin
        accept  = bus.in_valid && (state_q == ACCUM);
        last    = accept && (cnt == CW'(LEN-1));
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q    <= ACCUM;
            cnt        <= '0;
            acc        <= '0;
            ovf_trk    <= 1'b0;
            acc_out_q  <= '0;
            acc_prev_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (last) begin
                acc_out_q  <= acc_next;
                acc_prev_q <= step_prev;
                ovf_q      <= ovf_trk | step_ovf;
                acc        <= '0;
                cnt        <= '0;
                ovf_trk    <= 1'b0;
            end else if (accept) begin
                acc     <= acc_next;
                cnt     <= cnt + CW'(1);
                ovf_trk <= ovf_trk | step_ovf;
            end
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_prev  = acc_prev_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream: wrap (LEN=4), saturate (LEN=4), LEN=1.
module tb_mac_stream;
    import mac_stream_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    mac_result_t exp_q [3][$];

    logic [2:0]       iv, orv, ir, ov, ovf_o;
    logic signed [8:0] xv [3];
    logic signed [8:0] yv [3];
    logic signed [8:0] ao [3];
    logic signed [8:0] ap [3];

    mac_stream_if #(.DW(9), .AW(9)) b0 ();
    mac_stream_if #(.DW(9), .AW(9)) b1 ();
    mac_stream_if #(.DW(9), .AW(9)) b2 ();

    assign b0.in_valid = iv[0]; assign b0.x = xv[0]; assign b0.y = yv[0]; assign b0.out_ready = orv[0];
    assign b1.in_valid = iv[1]; assign b1.x = xv[1]; assign b1.y = yv[1]; assign b1.out_ready = orv[1];
    assign b2.in_valid = iv[2]; assign b2.x = xv[2]; assign b2.y = yv[2]; assign b2.out_ready = orv[2];
    assign ir[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign ao[0] = b0.acc_out; assign ap[0] = b0.acc_prev; assign ovf_o[0] = b0.ovf;
    assign ir[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign ao[1] = b1.acc_out; assign ap[1] = b1.acc_prev; assign ovf_o[1] = b1.ovf;
    assign ir[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign ao[2] = b2.acc_out; assign ap[2] = b2.acc_prev; assign ovf_o[2] = b2.ovf;

    mac_stream #(.DW(9), .AW(9), .LEN(4), .SAT(SAT_WRAP))  u_wrap (.system1000(clk), .system1000_rst(rst), .bus(b0));
    mac_stream #(.DW(9), .AW(9), .LEN(4), .SAT(SAT_CLAMP)) u_sat  (.system1000(clk), .system1000_rst(rst), .bus(b1));
    mac_stream #(.DW(9), .AW(9), .LEN(1), .SAT(SAT_WRAP))  u_one  (.system1000(clk), .system1000_rst(rst), .bus(b2));

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic push(int d, int a_out, int a_prev, bit o);
        mac_result_t r;
        r.acc_out  = 9'(a_out);
        r.acc_prev = 9'(a_prev);
        r.ovf      = o;
        exp_q[d].push_back(r);
    endtask

    task automatic check_result(int d);
        mac_result_t got, want;
        got.acc_out  = ao[d];
        got.acc_prev = ap[d];
        got.ovf      = ovf_o[d];
        n_cmp++;
        if (exp_q[d].size() == 0) begin
            n_fail++;
            $error("FAIL result_dut%0d: got unexpected result %0d/%0d/%0b want none", d, got.acc_out, got.acc_prev, got.ovf);
        end else begin
            want = exp_q[d].pop_front();
            assert (got === want) else begin
                n_fail++;
                $error("FAIL result_dut%0d: got out=%0d prev=%0d ovf=%0b want out=%0d prev=%0d ovf=%0b",
                       d, got.acc_out, got.acc_prev, got.ovf, want.acc_out, want.acc_prev, want.ovf);
            end
        end
    endtask

    // Called at posedge+1; holds the pair until the DUT takes it.
    task automatic send(int d, int a, int b);
        bit took;
        took  = 1'b0;
        iv[d] = 1'b1;
        xv[d] = 9'(a);
        yv[d] = 9'(b);
        for (int i = 0; i < 20 && !took; i++) begin
            @(negedge clk);
            took = ir[d];
            @(posedge clk); #1;
        end
        if (!took) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout_dut%0d: in_ready got 0 want 1", d);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int wrap9(int v, inout bit o);
        int t;
        t = v & 511;
        if (t > 255) t = t - 512;
        if (t != v) o = 1'b1;
        return t;
    endfunction

    initial begin
        #50000;
        $error("FAIL watchdog: simulation got stuck, want completion");
        $fatal(1);
    end

    initial begin
        int xa [4];
        int ya [4];
        int m_acc, m_prev, m_p;
        bit m_o;

        rst = 1'b1;
        iv  = '0;
        orv = '1;
        for (int d = 0; d < 3; d++) begin xv[d] = '0; yv[d] = '0; end

        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < 3; d++)
                    if (ov[d] && orv[d]) check_result(d);
            end
        join_none

        @(posedge clk); #1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready_%0d", d),  ir[d],    1);
            chk($sformatf("rst_out_valid_%0d", d), ov[d],    0);
            chk($sformatf("rst_acc_out_%0d", d),   ao[d],    0);
            chk($sformatf("rst_acc_prev_%0d", d),  ap[d],    0);
            chk($sformatf("rst_ovf_%0d", d),       ovf_o[d], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic wrap block, continuous valid; HOLD lasts exactly one cycle.
        push(0, 23, 16, 0);
        send(0, 3, 4); send(0, 2, 5); send(0, -1, 6); send(0, 7, 1);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("hold_out_valid", ov[0], 1);
        chk("hold_in_ready",  ir[0], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_hold_in_ready",  ir[0], 1);
        chk("after_hold_out_valid", ov[0], 0);
        @(posedge clk); #1;

        push(0, -112, -112, 1);
        send(0, 20, 20); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        iv[0] = 1'b0;
        cyc(2);

        // Back-pressure: a pair is offered during HOLD and must not be taken.
        orv[0] = 1'b0;
        push(0, -72, -16, 0);
        send(0, 1, 2); send(0, 3, 4); send(0, -5, 6); send(0, 7, -8);
        xv[0] = 9'sd9;
        yv[0] = 9'sd9;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", ov[0],    1);
            chk("bp_in_ready",  ir[0],    0);
            chk("bp_acc_out",   ao[0],    -72);
            chk("bp_acc_prev",  ap[0],    -16);
            chk("bp_ovf",       ovf_o[0], 0);
            @(posedge clk); #1;
        end
        iv[0]  = 1'b0;
        orv[0] = 1'b1;
        cyc(2);

        // Reset in the middle of a block discards it.
        send(0, 5, 5); send(0, 5, 5);
        iv[0] = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        push(0, 4, 3, 0);
        repeat (4) send(0, 1, 1);
        iv[0] = 1'b0;
        cyc(2);

        for (int blk = 0; blk < 3; blk++) begin
            m_acc  = 0;
            m_prev = 0;
            m_o    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                xa[k]  = int'($urandom_range(511)) - 256;
                ya[k]  = int'($urandom_range(511)) - 256;
                m_p    = wrap9(xa[k] * ya[k], m_o);
                m_prev = m_acc;
                m_acc  = wrap9(m_acc + m_p, m_o);
            end
            push(0, m_acc, m_prev, m_o);
            for (int k = 0; k < 4; k++) send(0, xa[k], ya[k]);
            iv[0] = 1'b0;
            cyc(2);
        end

        // Saturating instance.
        push(1, 255, 255, 1);
        send(1, 20, 20); send(1, 15, 15); send(1, 0, 0); send(1, 0, 0);
        iv[1] = 1'b0;
        cyc(2);
        push(1, -256, -256, 1);
        send(1, -16, 16); send(1, -1, 1); send(1, 0, 0); send(1, 0, 0);
        iv[1] = 1'b0;
        cyc(2);
        push(1, 4, 3, 0);
        repeat (4) send(1, 1, 1);
        iv[1] = 1'b0;
        cyc(2);

        // LEN=1 with in_valid toggling.
        push(2, -15, 0, 0);
        send(2, -5, 3); iv[2] = 1'b0; cyc(1);
        push(2, 4, 0, 0);
        send(2, 2, 2); iv[2] = 1'b0; cyc(1);
        push(2, -256, 0, 1);
        send(2, 16, 16); iv[2] = 1'b0; cyc(1);
        push(2, 1, 0, 0);
        send(2, 1, 1); iv[2] = 1'b0;
        cyc(3);

        for (int d = 0; d < 3; d++)
            chk($sformatf("queue_empty_%0d", d), exp_q[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
